// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch requester
// (if_*) and the load/store requester (d_*). Data accesses win arbitration,
// but after STREAK_MAX consecutive data grants with fetch waiting, fetch wins.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
//
// Ports:
//   clk, rstd                  clock, synchronous active-high reset
//   if_req/if_addr             fetch request (held until if_ready)
//   if_ready/if_rvalid/if_rdata fetch accept, response pulse, response data
//   d_req/d_we/d_wstrb/d_addr/d_wdata  load/store request
//   d_ready/d_rvalid/d_rdata   data accept, response pulse, load data (0 for stores)
//   m_en/m_we/m_wstrb/m_addr/m_wdata   memory strobe and write side
//   m_rdata                    memory read data, valid MEM_LAT cycles after m_en
//   busy                       FSM is not in IDLE
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_wstrb,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [3:0]    m_wstrb,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STREAK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            id_q, id_d;          // 1 = data requester owns the transaction
  logic            we_q, we_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            grant_d_s, grant_if_s;

  // Arbitration: data wins unless fetch has waited through a full streak.
  always_comb begin
    grant_d_s  = d_req && !(if_req && (streak_q == SW'(STREAK_MAX)));
    grant_if_s = if_req && !grant_d_s;
  end

  // Next-state, capture and response logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    id_d        = id_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready    = 1'b0;
    d_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rstd && grant_d_s) begin
          d_ready = 1'b1;
          id_d    = 1'b1;
          we_d    = d_we;
          wstrb_d = d_wstrb;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = ISSUE;
          // Streak only grows while fetch is actually being held off.
          if (if_req) begin
            streak_d = (streak_q == SW'(STREAK_MAX)) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (!rstd && grant_if_s) begin
          if_ready = 1'b1;
          id_d     = 1'b0;
          we_d     = 1'b0;
          wstrb_d  = 4'b0000;
          addr_d   = if_addr;
          wdata_d  = {DW{1'b0}};
          state_d  = ISSUE;
          streak_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_q reaches zero in the cycle m_rdata is valid.
        if (cnt_q == '0) begin
          state_d = RESP;
          if (id_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? {DW{1'b0}} : m_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstd) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'b0000;
      addr_q      <= {AW{1'b0}};
      wdata_q     <= {DW{1'b0}};
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= {DW{1'b0}};
      d_rdata_q   <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      id_q        <= id_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Memory-side outputs are decoded from registered state only.
  always_comb begin
    m_en      = (state_q == ISSUE);
    m_we      = m_en & we_q;
    m_wstrb   = m_en ? wstrb_q : 4'b0000;
    m_addr    = addr_q;
    m_wdata   = wdata_q;
    busy      = (state_q != IDLE);
    if_rvalid = if_rvalid_q;
    d_rvalid  = d_rvalid_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: one instance with MEM_LAT=2 for the
// main sequence and one with MEM_LAT=1 for the short-latency case.
module tb_mem_arbiter;

  logic        clk;
  logic        rstd;
  logic        if_req, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_rvalid;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_en, m_we, busy;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        x_if_req, x_if_ready, x_if_rvalid;
  logic [31:0] x_if_addr, x_if_rdata;
  logic        x_d_req, x_d_we, x_d_ready, x_d_rvalid;
  logic [3:0]  x_d_wstrb;
  logic [31:0] x_d_addr, x_d_wdata, x_d_rdata;
  logic        x_m_en, x_m_we, x_busy;
  logic [3:0]  x_m_wstrb;
  logic [31:0] x_m_addr, x_m_wdata, x_m_rdata;

  int n_checks;
  int n_fail;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STREAK_MAX(4)) dut (
    .clk(clk), .rstd(rstd),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STREAK_MAX(4)) dut1 (
    .clk(clk), .rstd(rstd),
    .if_req(x_if_req), .if_addr(x_if_addr), .if_ready(x_if_ready),
    .if_rvalid(x_if_rvalid), .if_rdata(x_if_rdata),
    .d_req(x_d_req), .d_we(x_d_we), .d_wstrb(x_d_wstrb), .d_addr(x_d_addr),
    .d_wdata(x_d_wdata), .d_ready(x_d_ready), .d_rvalid(x_d_rvalid), .d_rdata(x_d_rdata),
    .m_en(x_m_en), .m_we(x_m_we), .m_wstrb(x_m_wstrb), .m_addr(x_m_addr),
    .m_wdata(x_m_wdata), .m_rdata(x_m_rdata), .busy(x_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] t6_data [3];
  logic        exp_d;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    t6_data[0] = 32'hA5A5A5A5;
    t6_data[1] = 32'h5A5A5A5A;
    t6_data[2] = 32'h0F0F0F0F;
    rstd = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    m_rdata = 32'h0;
    x_if_req = 1'b0; x_if_addr = 32'h0;
    x_d_req = 1'b1; x_d_we = 1'b0; x_d_wstrb = 4'h0; x_d_addr = 32'h0; x_d_wdata = 32'h0;
    x_m_rdata = 32'h0;

    // Test 1: reset held with both requests present
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
      chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
      chk("rst_m_en", {31'd0, m_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_x_d_ready", {31'd0, x_d_ready}, 32'd0);
    end
    rstd = 1'b0; if_req = 1'b0; d_req = 1'b0; x_d_req = 1'b0;
    tick();
    chk("idle_no_ready", {30'd0, if_ready, d_ready}, 32'd0);

    // Test 2: single fetch, MEM_LAT=2
    if_req = 1'b1; if_addr = 32'h10; m_rdata = 32'h0BAD0BAD;
    #1;
    chk("t2_if_ready", {31'd0, if_ready}, 32'd1);
    chk("t2_d_ready", {31'd0, d_ready}, 32'd0);
    tick(); if_req = 1'b0; #1;
    chk("t2_m_en", {31'd0, m_en}, 32'd1);
    chk("t2_m_addr", m_addr, 32'h10);
    chk("t2_m_we", {31'd0, m_we}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t2_m_en_c2", {31'd0, m_en}, 32'd0);
    tick(); m_rdata = 32'hDEADBEEF;
    chk("t2_no_early_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick(); m_rdata = 32'h0BAD0BAD;
    chk("t2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t2_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick();
    chk("t2_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);
    chk("t2_idle", {31'd0, busy}, 32'd0);
    chk("t2_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Test 3: simultaneous fetch and store, data wins
    if_req = 1'b1; if_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    #1;
    chk("t3_d_ready", {31'd0, d_ready}, 32'd1);
    chk("t3_if_ready", {31'd0, if_ready}, 32'd0);
    tick(); d_req = 1'b0; d_we = 1'b0; #1;
    chk("t3_m_en", {31'd0, m_en}, 32'd1);
    chk("t3_m_we", {31'd0, m_we}, 32'd1);
    chk("t3_m_wstrb", {28'd0, m_wstrb}, 32'h3);
    chk("t3_m_wdata", m_wdata, 32'h12345678);
    chk("t3_m_addr", m_addr, 32'h40);
    chk("t3_ignored_in_issue", {31'd0, if_ready}, 32'd0);
    tick();
    tick(); m_rdata = 32'h55555555;
    tick();
    chk("t3_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t3_d_rdata_store", d_rdata, 32'd0);
    chk("t3_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick(); #1;
    chk("t3_fetch_next", {31'd0, if_ready}, 32'd1);
    tick(); if_req = 1'b0; #1;
    chk("t3_f_m_addr", m_addr, 32'h14);
    chk("t3_f_m_we", {27'd0, m_we, m_wstrb}, 32'd0);
    tick();
    tick(); m_rdata = 32'h11112222;
    tick();
    chk("t3_f_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t3_f_rdata", if_rdata, 32'h11112222);
    chk("t3_d_rdata_hold", d_rdata, 32'd0);
    tick();

    // Test 4: both requests held, streak limit forces every fifth grant to fetch
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_d = ((k % 5) != 4);
      chk("t4_d_ready", {31'd0, d_ready}, {31'd0, exp_d});
      chk("t4_if_ready", {31'd0, if_ready}, {31'd0, !exp_d});
      tick();
      chk("t4_no_ready_busy", {30'd0, if_ready, d_ready}, 32'd0);
      tick(); tick(); tick(); tick();
    end
    if_req = 1'b0; d_req = 1'b0;

    // Test 5: reset during a fetch aborts it
    if_req = 1'b1; if_addr = 32'h30; #1;
    chk("t5_if_ready", {31'd0, if_ready}, 32'd1);
    tick(); if_req = 1'b0; #1;
    chk("t5_m_en", {31'd0, m_en}, 32'd1);
    tick(); rstd = 1'b1; #1;
    chk("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    tick(); rstd = 1'b0; m_rdata = 32'h77777777;
    chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t5_m_en_after_rst", {31'd0, m_en}, 32'd0);
    chk("t5_rdata_cleared", if_rdata, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("t5_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      if (c < 2) tick();
    end
    if_req = 1'b1; if_addr = 32'h20; #1;
    chk("t5_refetch_ready", {31'd0, if_ready}, 32'd1);
    tick(); if_req = 1'b0; #1;
    chk("t5_refetch_addr", m_addr, 32'h20);
    tick();
    tick(); m_rdata = 32'hCAFEF00D;
    tick();
    chk("t5_refetch_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t5_refetch_rdata", if_rdata, 32'hCAFEF00D);
    tick();

    // Test 6: MEM_LAT=1 back-to-back loads, one accept every 4 cycles
    x_d_req = 1'b1; x_m_rdata = 32'h0BAD0BAD;
    for (int k = 0; k < 3; k++) begin
      x_d_addr = 32'h8 + 32'(4 * k); #1;
      chk("t6_ready", {31'd0, x_d_ready}, 32'd1);
      tick();
      chk("t6_m_en", {31'd0, x_m_en}, 32'd1);
      chk("t6_m_addr", x_m_addr, 32'h8 + 32'(4 * k));
      chk("t6_no_ready_issue", {31'd0, x_d_ready}, 32'd0);
      tick(); x_m_rdata = t6_data[k];
      chk("t6_no_early_rvalid", {31'd0, x_d_rvalid}, 32'd0);
      tick(); x_m_rdata = 32'h0BAD0BAD;
      chk("t6_rvalid", {31'd0, x_d_rvalid}, 32'd1);
      chk("t6_rdata", x_d_rdata, t6_data[k]);
      chk("t6_no_ready_resp", {31'd0, x_d_ready}, 32'd0);
      tick();
    end
    x_d_req = 1'b0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
